// File: rtl/icache_axi_rd_bridge_pkg.sv
// Shared AXI4 constants and helpers for the instruction-cache read bridge.
package icache_axi_rd_bridge_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [7:0] AXI_LEN_SINGLE = 8'd0;

  // Pick the 32-bit instruction word out of a 64-bit read beat.
  function automatic logic [31:0] select_word(input logic [63:0] data, input logic hi);
    return hi ? data[63:32] : data[31:0];
  endfunction

endpackage

// File: rtl/icache_axi_rd_bridge.sv
// Single-outstanding AXI4 read bridge: turns an instruction-cache fetch request into one
// single-beat 32-bit AXI read, returns the selected word and error flag, then enforces a
// short hold-off before the next request is accepted.
module icache_axi_rd_bridge
  import icache_axi_rd_bridge_pkg::*;
#(
  parameter logic [3:0]  AXI_ID   = 4'h0,
  parameter int unsigned HOLD_CYC = 2
) (
  input  logic        clk,
  input  logic        rst,
  // Instruction cache side
  input  logic        cache_read_ena,
  input  logic [63:0] cache_addr,
  output logic [31:0] cache_or_data,
  output logic        cache_in_ok,
  output logic        rd_err,
  // AXI read address channel
  output logic        axi_ar_valid,
  input  logic        axi_ar_ready,
  output logic [63:0] axi_ar_addr,
  output logic [3:0]  axi_ar_id,
  output logic [7:0]  axi_ar_len,
  output logic [2:0]  axi_ar_size,
  output logic [1:0]  axi_ar_burst,
  // AXI read data channel
  input  logic        axi_r_valid,
  output logic        axi_r_ready,
  input  logic [63:0] axi_r_data,
  input  logic [1:0]  axi_r_resp,
  input  logic        axi_r_last,
  input  logic [3:0]  axi_r_id
);

  typedef enum logic [4:0] {
    StIdle = 5'b00001,
    StAr   = 5'b00010,
    StR    = 5'b00100,
    StDone = 5'b01000,
    StHold = 5'b10000
  } state_e;

  state_e      state_q, state_d;
  logic [63:2] addr_q, addr_d;   // word-aligned fetch address latched in IDLE
  logic [31:0] data_q, data_d;
  logic        err_q, err_d;
  logic [2:0]  cnt_q, cnt_d;

  // Byte offset within the word never reaches the bus.
  logic unused_addr;
  assign unused_addr = ^cache_addr[1:0];

  // Next-state, address latch, data capture and hold counter.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (cache_read_ena) begin
          addr_d  = cache_addr[63:2];
          state_d = StAr;
        end
      end
      StAr: begin
        if (axi_ar_ready) state_d = StR;
      end
      StR: begin
        // Beats carrying a foreign ID are consumed (r_ready is high) but ignored.
        if (axi_r_valid && axi_r_last && (axi_r_id == AXI_ID)) begin
          data_d  = select_word(axi_r_data, addr_q[2]);
          err_d   = (axi_r_resp != AXI_RESP_OKAY);
          state_d = StDone;
        end
      end
      StDone: begin
        cnt_d   = HOLD_CYC[2:0];
        state_d = StHold;
      end
      StHold: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q <= 3'd1) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; reset abandons any in-flight read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs decoded from the registered state, so AR fields are stable while AR is held.
  assign axi_ar_valid  = (state_q == StAr);
  assign axi_r_ready   = (state_q == StR);
  assign axi_ar_addr   = {addr_q, 2'b00};
  assign axi_ar_id     = AXI_ID;
  assign axi_ar_len    = AXI_LEN_SINGLE;
  assign axi_ar_size   = AXI_SIZE_4B;
  assign axi_ar_burst  = AXI_BURST_INCR;
  assign cache_in_ok   = (state_q == StDone);
  assign rd_err        = (state_q == StDone) && err_q;
  assign cache_or_data = data_q;

endmodule

// File: tb/tb_icache_axi_rd_bridge.sv
// Self-checking bench for icache_axi_rd_bridge: directed scenarios plus randomized
// transactions compared against a transaction-level expectation.
module tb_icache_axi_rd_bridge;

  localparam logic [3:0] TB_ID = 4'h3;
  localparam int unsigned TB_HOLD = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        cache_read_ena;
  logic [63:0] cache_addr;
  logic [31:0] cache_or_data;
  logic        cache_in_ok;
  logic        rd_err;
  logic        axi_ar_valid;
  logic        axi_ar_ready;
  logic [63:0] axi_ar_addr;
  logic [3:0]  axi_ar_id;
  logic [7:0]  axi_ar_len;
  logic [2:0]  axi_ar_size;
  logic [1:0]  axi_ar_burst;
  logic        axi_r_valid;
  logic        axi_r_ready;
  logic [63:0] axi_r_data;
  logic [1:0]  axi_r_resp;
  logic        axi_r_last;
  logic [3:0]  axi_r_id;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  icache_axi_rd_bridge #(
    .AXI_ID  (TB_ID),
    .HOLD_CYC(TB_HOLD)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cache_read_ena(cache_read_ena),
    .cache_addr    (cache_addr),
    .cache_or_data (cache_or_data),
    .cache_in_ok   (cache_in_ok),
    .rd_err        (rd_err),
    .axi_ar_valid  (axi_ar_valid),
    .axi_ar_ready  (axi_ar_ready),
    .axi_ar_addr   (axi_ar_addr),
    .axi_ar_id     (axi_ar_id),
    .axi_ar_len    (axi_ar_len),
    .axi_ar_size   (axi_ar_size),
    .axi_ar_burst  (axi_ar_burst),
    .axi_r_valid   (axi_r_valid),
    .axi_r_ready   (axi_r_ready),
    .axi_r_data    (axi_r_data),
    .axi_r_resp    (axi_r_resp),
    .axi_r_last    (axi_r_last),
    .axi_r_id      (axi_r_id)
  );

  task automatic chk(input logic [63:0] obs, input logic [63:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled and inputs driven 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    chk(64'(axi_ar_valid & axi_r_ready), 64'd0, "ar_r_exclusive");
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk(64'(cache_or_data), 64'd0, {tag, "_data"});
    chk(64'(cache_in_ok), 64'd0, {tag, "_in_ok"});
    chk(64'(rd_err), 64'd0, {tag, "_rd_err"});
    chk(64'(axi_ar_valid), 64'd0, {tag, "_ar_valid"});
    chk(64'(axi_r_ready), 64'd0, {tag, "_r_ready"});
  endtask

  task automatic clear_r();
    axi_r_valid = 1'b0;
    axi_r_last  = 1'b0;
    axi_r_id    = 4'h0;
    axi_r_data  = '0;
    axi_r_resp  = 2'b00;
  endtask

  // One complete fetch. Expected word/error come from the transaction description only.
  task automatic do_txn(input logic [63:0] addr, input logic [63:0] alt_addr,
                        input int ar_dly, input int r_dly, input int n_bad,
                        input logic [63:0] data, input logic [1:0] resp,
                        output int waited);
    logic [63:0] exp_ar;
    logic [31:0] exp_word;
    logic        exp_err;
    exp_ar   = addr & ~64'h3;
    exp_word = addr[2] ? data[63:32] : data[31:0];
    exp_err  = (resp != 2'b00);
    cache_addr     = addr;
    cache_read_ena = 1'b1;
    waited = 0;
    while (!axi_ar_valid && waited < 20) begin
      tick();
      waited++;
    end
    chk(64'(axi_ar_valid), 64'd1, "ar_valid_rise");
    chk(axi_ar_addr, exp_ar, "ar_addr");
    chk(64'(axi_ar_id), 64'(TB_ID), "ar_id");
    chk(64'(axi_ar_len), 64'd0, "ar_len");
    chk(64'(axi_ar_size), 64'd2, "ar_size");
    chk(64'(axi_ar_burst), 64'd1, "ar_burst");
    cache_addr = alt_addr;  // must not disturb the request in flight
    for (int i = 0; i < ar_dly; i++) begin
      tick();
      chk(64'(axi_ar_valid), 64'd1, "ar_valid_held");
      chk(axi_ar_addr, exp_ar, "ar_addr_stable");
    end
    axi_ar_ready = 1'b1;
    tick();
    axi_ar_ready = 1'b0;
    chk(64'(axi_ar_valid), 64'd0, "ar_valid_drop");
    chk(64'(axi_r_ready), 64'd1, "r_ready");
    for (int i = 0; i < r_dly; i++) begin
      tick();
      chk(64'(cache_in_ok), 64'd0, "no_ok_before_r");
    end
    for (int i = 0; i < n_bad; i++) begin
      axi_r_valid = 1'b1;
      axi_r_last  = 1'b1;
      axi_r_id    = TB_ID + 4'h1;
      axi_r_data  = {$urandom, $urandom};
      axi_r_resp  = 2'($urandom);
      tick();
      chk(64'(cache_in_ok), 64'd0, "bad_id_discard");
      chk(64'(axi_r_ready), 64'd1, "r_ready_after_bad");
    end
    axi_r_valid = 1'b1;
    axi_r_last  = 1'b1;
    axi_r_id    = TB_ID;
    axi_r_data  = data;
    axi_r_resp  = resp;
    tick();
    clear_r();
    chk(64'(cache_in_ok), 64'd1, "in_ok");
    chk(64'(cache_or_data), 64'(exp_word), "or_data");
    chk(64'(rd_err), 64'(exp_err), "rd_err");
    cache_read_ena = 1'b0;
    tick();
    chk(64'(cache_in_ok), 64'd0, "in_ok_one_cycle");
    chk(64'(rd_err), 64'd0, "rd_err_one_cycle");
    chk(64'(cache_or_data), 64'(exp_word), "or_data_held");
    chk(64'(axi_ar_valid), 64'd0, "no_ar_in_hold");
  endtask

  initial begin
    int w;
    rst            = 1'b1;
    cache_read_ena = 1'b0;
    cache_addr     = '0;
    axi_ar_ready   = 1'b0;
    clear_r();
    tick();
    tick();
    chk_reset_outputs("reset");
    rst = 1'b0;
    tick();

    // Word select high, OKAY response.
    do_txn(64'h8000_0004, 64'h1234_0000, 0, 0, 0, 64'h1111_2222_3333_4444, 2'b00, w);
    // AR stalled 5 cycles while the cache address moves.
    do_txn(64'h8000_0000, 64'h9000_0000, 5, 1, 0, 64'hAAAA_BBBB_CCCC_DDDD, 2'b00, w);
    // Error response still returns data.
    do_txn(64'h0000_0000, 64'h0000_0010, 0, 0, 0, 64'h0123_4567_DEAD_BEEF, 2'b10, w);
    // Foreign-ID beat ahead of the real one.
    do_txn(64'h4000_0008, 64'h0, 1, 0, 1, 64'h5555_6666_7777_8888, 2'b00, w);

    // Minimum latency and hold spacing with everything ready immediately.
    repeat (4) tick();
    axi_ar_ready = 1'b1;
    axi_r_valid  = 1'b1;
    axi_r_last   = 1'b1;
    axi_r_id     = TB_ID;
    axi_r_data   = 64'hFEED_F00D_0BAD_CAFE;
    axi_r_resp   = 2'b00;
    cache_addr   = 64'h2000_0004;
    cache_read_ena = 1'b1;
    tick();
    tick();
    chk(64'(cache_in_ok), 64'd0, "lat_not_yet");
    tick();
    chk(64'(cache_in_ok), 64'd1, "lat_in_ok_cycle3");
    chk(64'(cache_or_data), 64'h0000_0000_FEED_F00D, "lat_data");
    // Request stays high: next AR appears only after DONE + 2 hold cycles + IDLE accept.
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk(64'(axi_ar_valid), 64'd0, "hold_no_ar");
    end
    tick();
    chk(64'(axi_ar_valid), 64'd1, "hold_then_ar");
    tick();
    tick();
    chk(64'(cache_in_ok), 64'd1, "hold_second_ok");
    cache_read_ena = 1'b0;
    axi_ar_ready   = 1'b0;
    clear_r();
    repeat (4) tick();

    // Reset in the middle of the R phase.
    cache_addr     = 64'h3000_0000;
    cache_read_ena = 1'b1;
    tick();
    axi_ar_ready = 1'b1;
    tick();
    axi_ar_ready = 1'b0;
    chk(64'(axi_r_ready), 64'd1, "pre_reset_in_r");
    rst = 1'b1;
    #1;
    chk(64'(axi_r_ready), 64'd0, "async_reset_r_ready");
    cache_read_ena = 1'b0;
    tick();
    chk_reset_outputs("midreset");
    rst = 1'b0;
    do_txn(64'h3000_0004, 64'h0, 0, 0, 0, 64'h9999_8888_7777_6666, 2'b01, w);
    chk(64'(w), 64'd1, "first_cycle_accept");

    // Randomized transactions; expectation derived from address/data/resp alone.
    for (int t = 0; t < 10; t++) begin
      logic [63:0] a, d;
      a = {$urandom, $urandom};
      d = {$urandom, $urandom};
      do_txn(a, {$urandom, $urandom}, int'($urandom_range(0, 4)), int'($urandom_range(0, 3)),
             int'($urandom_range(0, 2)), d, 2'($urandom), w);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/icache_axi_rd_bridge.md
ICACHE_AXI_RD_BRIDGE -- requirements
Module: icache_axi_rd_bridge

Interface
REQ-001 Parameter AXI_ID, default 4'h0, fixed AR ID of every issued read.
REQ-002 Parameter HOLD_CYC, default 2, idle cycles after each cache_in_ok during which cache_read_ena is ignored (range 1..7).
REQ-003 clk  input  1  sole clock, all state on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 cache_read_ena  input  1  level request from instruction cache, held until cache_in_ok.
REQ-006 cache_addr  input  64  instruction fetch byte address.
REQ-007 cache_or_data  output  32  returned instruction word.
REQ-008 cache_in_ok  output  1  one-cycle pulse, cache_or_data valid.
REQ-009 rd_err  output  1  one-cycle pulse coincident with cache_in_ok when r_resp != OKAY.
REQ-010 axi_ar_valid / axi_ar_ready  output / input  1 / 1  AR handshake.
REQ-011 axi_ar_addr  output  64; axi_ar_id  output  4; axi_ar_len  output  8; axi_ar_size  output  3; axi_ar_burst  output  2.
REQ-012 axi_r_valid  input  1; axi_r_ready  output  1; axi_r_data  input  64; axi_r_resp  input  2; axi_r_last  input  1; axi_r_id  input  4.

Function
REQ-013 FSM states IDLE, AR, R, DONE, HOLD; one-hot encoding.
REQ-014 IDLE: cache_read_ena=1 latches cache_addr into addr_q, next state AR; else stay.
REQ-015 AR: axi_ar_valid=1, axi_ar_addr={addr_q[63:2],2'b00}, ar_id=AXI_ID, ar_len=0, ar_size=3'b010, ar_burst=INCR; on ar_valid&&ar_ready -> R.
REQ-016 ar_valid, once high, SHALL stay high with stable AR fields until ar_ready (no withdrawal).
REQ-017 R: axi_r_ready=1; on r_valid&&r_ready&&r_last&&(r_id==AXI_ID) capture word -> DONE; beats with r_id!=AXI_ID are accepted and discarded.
REQ-018 Word select: addr_q[2]=0 -> r_data[31:0], addr_q[2]=1 -> r_data[63:32].
REQ-019 DONE: cache_in_ok=1 for exactly one cycle; rd_err=1 iff captured r_resp!=2'b00; -> HOLD.
REQ-020 cache_or_data SHALL be a register, holding last captured word until next capture.
REQ-021 HOLD: counter loads HOLD_CYC, decrements per cycle, cache_read_ena ignored; at zero -> IDLE.
REQ-022 Minimum latency cache_read_ena rise to cache_in_ok = 3 cycles with ar_ready and r_valid asserted immediately.
REQ-023 At most one outstanding AXI read; axi_ar_valid and axi_r_ready never high together.
REQ-024 cache_addr changes after the IDLE latch cycle SHALL not affect the transaction in flight.
REQ-025 Error response data SHALL still be returned on cache_or_data.

Reset
REQ-026 rst=1 forces IDLE asynchronously, any cycle including mid-transaction; in-flight AXI read abandoned.
REQ-027 Reset values: cache_or_data=0, cache_in_ok=0, rd_err=0, axi_ar_valid=0, axi_r_ready=0, addr_q=0, hold counter=0.
REQ-028 First request accepted in first cycle after rst deasserts.

Structure
REQ-029 AXI constants (BURST_INCR=2'b01, SIZE_4B=3'b010, RESP_OKAY=2'b00) and reset-polarity macro come from the shared AXI4/global defines includes, not local literals.
REQ-030 FSM state encodings local to the module; no sub-module.

Verification
REQ-031 cache_addr=0x8000_0004, ar_ready=1, r_valid next cycle, r_data=0x1111_2222_3333_4444, resp=0 -> ar_addr=0x8000_0004, cache_or_data=0x1111_2222, cache_in_ok pulse at cycle 3, rd_err=0.
REQ-032 ar_ready delayed 5 cycles, cache_addr changed to 0x9000_0000 meanwhile -> ar_valid held 5 cycles, ar_addr stays 0x8000_0000.
REQ-033 r_resp=2'b10, r_data low word 0xDEAD_BEEF, addr[2]=0 -> cache_or_data=0xDEAD_BEEF, cache_in_ok and rd_err both pulse once.
REQ-034 cache_read_ena held high continuously, HOLD_CYC=2 -> exactly 2 cycles between cache_in_ok and next ar_valid-initiating IDLE acceptance, no extra AR issued in HOLD.
REQ-035 rst asserted while in R -> next cycle all outputs at reset values; new request after release completes normally.
REQ-036 Beat with r_id=AXI_ID+1 then correct beat -> first discarded, cache_in_ok only after correct beat.
